// File: rtl/enigma_pkg.sv
// Shared constants, rotor tables and modular helpers for the Enigma rotor stages.
package enigma_pkg;

    localparam int ALPHA      = 26;
    localparam int W          = 5;
    localparam int NUM_ROTORS = 5;

    typedef logic [W-1:0]       letter_t;
    typedef logic [ALPHA*W-1:0] table_t;   // entry i lives at [W*i +: W]

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Historical wirings of rotors I..V, letter A first (in the MSBs).
    localparam logic [ALPHA*8-1:0] WIRING_STR [1:NUM_ROTORS] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLWMQCFAJKOEX"
    };

    // Turnover happens when stepping away from this position (Q, E, V, J, Z).
    localparam int NOTCH [1:NUM_ROTORS] = '{16, 4, 21, 9, 25};

    // Builds the packed forward table, or its inverse, from the wiring string.
    function automatic table_t rotor_table(input int id, input dir_e dir);
        table_t     t;
        logic [7:0] c;
        int         o;
        t = '0;
        for (int i = 0; i < ALPHA; i++) begin
            c = WIRING_STR[id][8*(ALPHA-1-i) +: 8];
            o = int'(c) - 65;
            if (dir == DIR_FWD)
                t[W*i +: W] = W'(o);
            else
                t[W*o +: W] = W'(i);
        end
        return t;
    endfunction

    localparam table_t WIRING [1:NUM_ROTORS] = '{
        rotor_table(1, DIR_FWD), rotor_table(2, DIR_FWD), rotor_table(3, DIR_FWD),
        rotor_table(4, DIR_FWD), rotor_table(5, DIR_FWD)
    };

    localparam table_t INV_WIRING [1:NUM_ROTORS] = '{
        rotor_table(1, DIR_REV), rotor_table(2, DIR_REV), rotor_table(3, DIR_REV),
        rotor_table(4, DIR_REV), rotor_table(5, DIR_REV)
    };

    // (a + b) mod ALPHA for a, b < ALPHA; one conditional subtract suffices.
    function automatic letter_t mod_add(input letter_t a, input letter_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (W+1)'(ALPHA))
            s = s - (W+1)'(ALPHA);
        return s[W-1:0];
    endfunction

    // (a - b) mod ALPHA; ALPHA is added first so the intermediate never goes negative.
    function automatic letter_t mod_sub(input letter_t a, input letter_t b);
        logic [W:0] s;
        s = {1'b0, a} + (W+1)'(ALPHA) - {1'b0, b};
        if (s >= (W+1)'(ALPHA))
            s = s - (W+1)'(ALPHA);
        return s[W-1:0];
    endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// Combinational rotor substitution: shift into rotor frame, look up, shift back.
module enigma_rotor_map
    import enigma_pkg::*;
#(
    parameter int   ROTOR_ID = 1,
    parameter dir_e DIR      = DIR_FWD
) (
    input  letter_t x,
    input  letter_t position,
    input  letter_t ring,
    output letter_t y
);

    localparam table_t TABLE = (DIR == DIR_FWD) ? WIRING[ROTOR_ID] : INV_WIRING[ROTOR_ID];

    letter_t k;
    letter_t t;

    // Contact offset is position minus ring setting, applied on entry and removed on exit.
    always_comb begin
        k = mod_sub(mod_add(x, position), ring);
        t = TABLE[int'(k)*W +: W];
        y = mod_add(mod_sub(t, position), ring);
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// One clocked Enigma rotor: position register with notch carry, registered
// forward/reverse substitution paths and a sticky error flag.
module enigma_rotor_stage #(
    parameter int ALPHA    = 26,
    parameter int W        = 5,
    parameter int ROTOR_ID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] pos_load,
    input  logic [W-1:0] ring,
    input  logic         step_in,
    output logic         step_out,
    output logic [W-1:0] position,
    input  logic         fwd_valid_in,
    input  logic [W-1:0] fwd_in,
    output logic         fwd_valid,
    output logic [W-1:0] fwd_out,
    input  logic         rev_valid_in,
    input  logic [W-1:0] rev_in,
    output logic         rev_valid,
    output logic [W-1:0] rev_out,
    output logic         err,
    output logic         done_out
);

    import enigma_pkg::*;

    localparam logic [W-1:0] NOTCH_POS = W'(NOTCH[ROTOR_ID]);
    localparam logic [W-1:0] LAST_POS  = W'(ALPHA - 1);
    localparam logic [W:0]   ALPHA_W   = (W+1)'(ALPHA);

    logic [W-1:0] position_reg, position_next;
    logic         err_reg, err_next;
    logic         fwd_valid_reg, rev_valid_reg;
    logic [W-1:0] fwd_out_reg, rev_out_reg;

    logic         fwd_ok, rev_ok, pos_ok;
    logic [W-1:0] map_x [2];
    logic [W-1:0] map_y [2];

    assign fwd_ok = {1'b0, fwd_in}   < ALPHA_W;
    assign rev_ok = {1'b0, rev_in}   < ALPHA_W;
    assign pos_ok = {1'b0, pos_load} < ALPHA_W;

    // Out-of-range letters are forced to 0 so the lookup never leaves the table.
    assign map_x[0] = fwd_ok ? fwd_in : '0;
    assign map_x[1] = rev_ok ? rev_in : '0;

    // Both directions see the pre-step position held in the register this cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_map
            enigma_rotor_map #(
                .ROTOR_ID (ROTOR_ID),
                .DIR      ((gi == 0) ? DIR_FWD : DIR_REV)
            ) u_map (
                .x        (map_x[gi]),
                .position (position_reg),
                .ring     (ring),
                .y        (map_y[gi])
            );
        end
    endgenerate

    // Turnover carry leaves in the same cycle as the step that moves off the notch.
    assign step_out = step_in & ~load & (position_reg == NOTCH_POS);

    // Next position: load wins over step; bad load values fall back to 0.
    always_comb begin
        position_next = position_reg;
        if (load)
            position_next = pos_ok ? pos_load : '0;
        else if (step_in)
            position_next = (position_reg == LAST_POS) ? '0 : position_reg + 1'b1;
        err_next = err_reg
                 | (fwd_valid_in & ~fwd_ok)
                 | (rev_valid_in & ~rev_ok)
                 | (load & ~pos_ok);
    end

    // Position register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            position_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            position_reg <= position_next;
            err_reg      <= err_next;
        end
    end

    // Forward path output register; data holds between valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_reg <= 1'b0;
            fwd_out_reg   <= '0;
        end else begin
            fwd_valid_reg <= fwd_valid_in;
            if (fwd_valid_in)
                fwd_out_reg <= fwd_ok ? map_y[0] : '0;
        end
    end

    // Reverse path output register; data holds between valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            rev_valid_reg <= 1'b0;
            rev_out_reg   <= '0;
        end else begin
            rev_valid_reg <= rev_valid_in;
            if (rev_valid_in)
                rev_out_reg <= rev_ok ? map_y[1] : '0;
        end
    end

    assign position  = position_reg;
    assign err       = err_reg;
    assign fwd_valid = fwd_valid_reg;
    assign fwd_out   = fwd_out_reg;
    assign rev_valid = rev_valid_reg;
    assign rev_out   = rev_out_reg;
    assign done_out  = fwd_valid_reg & rev_valid_reg;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for a rotor I stage: substitution, ring, stepping, load priority,
// error handling, reset and a forward/reverse round trip sweep.
module tb_enigma_rotor_stage;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] pos_load;
    logic [W-1:0] ring;
    logic         step_in;
    logic         step_out;
    logic [W-1:0] position;
    logic         fwd_valid_in;
    logic [W-1:0] fwd_in;
    logic         fwd_valid;
    logic [W-1:0] fwd_out;
    logic         rev_valid_in;
    logic [W-1:0] rev_in;
    logic         rev_valid;
    logic [W-1:0] rev_out;
    logic         err;
    logic         done_out;

    int errors = 0;
    int checks = 0;

    string rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    enigma_rotor_stage #(.ALPHA(26), .W(5), .ROTOR_ID(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .pos_load     (pos_load),
        .ring         (ring),
        .step_in      (step_in),
        .step_out     (step_out),
        .position     (position),
        .fwd_valid_in (fwd_valid_in),
        .fwd_in       (fwd_in),
        .fwd_valid    (fwd_valid),
        .fwd_out      (fwd_out),
        .rev_valid_in (rev_valid_in),
        .rev_in       (rev_in),
        .rev_valid    (rev_valid),
        .rev_out      (rev_out),
        .err          (err),
        .done_out     (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference substitution for rotor I straight from the wiring string.
    function automatic int model_fwd(input int x, input int p, input int r);
        int k;
        int y;
        k = (x + p - r + 52) % 26;
        y = int'(rotor_i[k]) - 65;
        return (y - p + r + 52) % 26;
    endfunction

    task automatic load_pos(input int p);
        load = 1'b1; pos_load = W'(p);
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (position !== 5'd0) begin errors++; $display("FAIL reset_position got=%0d exp=0", position); end
        checks++;
        if ({fwd_valid, rev_valid, done_out, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {fwd_valid, rev_valid, done_out, err});
        end
        checks++;
        if ({fwd_out, rev_out} !== 10'd0) begin errors++; $display("FAIL reset_data got=%0d/%0d exp=0/0", fwd_out, rev_out); end
        $display("txn reset: pos=%0d fv=%b rv=%b err=%b", position, fwd_valid, rev_valid, err);
    endtask

    task automatic test_basic_pos0();
        ring = 5'd0;
        fwd_valid_in = 1'b1; fwd_in = 5'd0;
        rev_valid_in = 1'b1; rev_in = 5'd4;
        tick();
        fwd_valid_in = 1'b0; rev_valid_in = 1'b0;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_out !== 5'd4) begin errors++; $display("FAIL fwd_A_pos0 got=%b/%0d exp=1/4", fwd_valid, fwd_out); end
        checks++;
        if (rev_valid !== 1'b1 || rev_out !== 5'd0) begin errors++; $display("FAIL rev_E_pos0 got=%b/%0d exp=1/0", rev_valid, rev_out); end
        checks++;
        if (done_out !== 1'b1) begin errors++; $display("FAIL done_both got=%b exp=1", done_out); end
        $display("txn pos0: fwd 0->%0d rev 4->%0d done=%b", fwd_out, rev_out, done_out);
        tick();
        checks++;
        if ({fwd_valid, rev_valid, done_out} !== 3'b000) begin
            errors++; $display("FAIL valid_drop got=%b exp=000", {fwd_valid, rev_valid, done_out});
        end
    endtask

    task automatic test_load_pos1();
        load_pos(1);
        checks++;
        if (position !== 5'd1) begin errors++; $display("FAIL load_pos1 got=%0d exp=1", position); end
        fwd_valid_in = 1'b1; fwd_in = 5'd0;
        rev_valid_in = 1'b1; rev_in = 5'd9;
        tick();
        fwd_valid_in = 1'b0; rev_valid_in = 1'b0;
        checks++;
        if (fwd_out !== 5'd9) begin errors++; $display("FAIL fwd_A_pos1 got=%0d exp=9", fwd_out); end
        checks++;
        if (rev_out !== 5'd0) begin errors++; $display("FAIL rev_J_pos1 got=%0d exp=0", rev_out); end
        $display("txn pos1: fwd 0->%0d rev 9->%0d", fwd_out, rev_out);
    endtask

    task automatic test_ring();
        load_pos(0);
        ring = 5'd1;
        fwd_valid_in = 1'b1; fwd_in = 5'd0;
        tick();
        fwd_valid_in = 1'b0;
        checks++;
        if (fwd_out !== 5'd10) begin errors++; $display("FAIL fwd_ring1 got=%0d exp=10", fwd_out); end
        $display("txn ring1: fwd 0->%0d", fwd_out);
        ring = 5'd0;
    endtask

    task automatic test_stepping();
        load_pos(15);
        step_in = 1'b1; #1;
        checks++;
        if (step_out !== 1'b0) begin errors++; $display("FAIL no_carry_pos15 got=%b exp=0", step_out); end
        tick();
        checks++;
        if (step_out !== 1'b1) begin errors++; $display("FAIL carry_pos16 got=%b exp=1", step_out); end
        tick();
        step_in = 1'b0; #1;
        checks++;
        if (position !== 5'd17 || step_out !== 1'b0) begin
            errors++; $display("FAIL step_to17 got=%0d/%b exp=17/0", position, step_out);
        end
        $display("txn step: 15->16->%0d", position);
        load_pos(25);
        step_in = 1'b1; #1;
        checks++;
        if (step_out !== 1'b0) begin errors++; $display("FAIL no_carry_wrap got=%b exp=0", step_out); end
        tick();
        step_in = 1'b0;
        checks++;
        if (position !== 5'd0) begin errors++; $display("FAIL wrap_to0 got=%0d exp=0", position); end
        $display("txn step: 25->%0d", position);
    endtask

    task automatic test_load_priority();
        load_pos(16);
        load = 1'b1; pos_load = 5'd5; step_in = 1'b1; #1;
        checks++;
        if (step_out !== 1'b0) begin errors++; $display("FAIL load_blocks_carry got=%b exp=0", step_out); end
        tick();
        load = 1'b0; step_in = 1'b0;
        checks++;
        if (position !== 5'd5) begin errors++; $display("FAIL load_over_step got=%0d exp=5", position); end
        $display("txn load+step: pos=%0d", position);
        // Data in a step cycle must see the old position (1 gives J, 2 would give K).
        load_pos(1);
        step_in = 1'b1; fwd_valid_in = 1'b1; fwd_in = 5'd0;
        tick();
        step_in = 1'b0; fwd_valid_in = 1'b0;
        checks++;
        if (fwd_out !== 5'd9 || position !== 5'd2) begin
            errors++; $display("FAIL step_uses_old_pos got=%0d/pos%0d exp=9/pos2", fwd_out, position);
        end
        $display("txn step+data: fwd 0->%0d pos=%0d", fwd_out, position);
    endtask

    task automatic test_invalid();
        rst = 1'b1; tick(); rst = 1'b0;
        fwd_valid_in = 1'b1; fwd_in = 5'd27;
        tick();
        fwd_valid_in = 1'b0;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_out !== 5'd0 || err !== 1'b1) begin
            errors++; $display("FAIL bad_letter got=v%b/d%0d/e%b exp=v1/d0/e1", fwd_valid, fwd_out, err);
        end
        fwd_valid_in = 1'b1; fwd_in = 5'd3;
        tick(); tick();
        fwd_valid_in = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        $display("txn bad letter: out=%0d err=%b", fwd_out, err);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", err); end
        rev_valid_in = 1'b1; rev_in = 5'd26;
        tick();
        rev_valid_in = 1'b0;
        checks++;
        if (rev_valid !== 1'b1 || rev_out !== 5'd0 || err !== 1'b1) begin
            errors++; $display("FAIL bad_rev_letter got=v%b/d%0d/e%b exp=v1/d0/e1", rev_valid, rev_out, err);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        load_pos(7);
        load_pos(30);
        checks++;
        if (position !== 5'd0 || err !== 1'b1) begin
            errors++; $display("FAIL bad_pos_load got=%0d/e%b exp=0/e1", position, err);
        end
        $display("txn bad pos_load: pos=%0d err=%b", position, err);
    endtask

    task automatic test_reset_midstream();
        load_pos(9);
        fwd_valid_in = 1'b1; fwd_in = 5'd4;
        rev_valid_in = 1'b1; rev_in = 5'd4;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; fwd_valid_in = 1'b0; rev_valid_in = 1'b0;
        checks++;
        if ({fwd_valid, rev_valid, done_out, err} !== 4'b0000 || {fwd_out, rev_out, position} !== 15'd0) begin
            errors++;
            $display("FAIL reset_midstream got=fv%b rv%b d%b e%b f%0d r%0d p%0d exp=all0",
                     fwd_valid, rev_valid, done_out, err, fwd_out, rev_out, position);
        end
        $display("txn reset midstream: pos=%0d fv=%b", position, fwd_valid);
    endtask

    task automatic test_round_trip();
        int pos_set  [4] = '{0, 7, 16, 25};
        int ring_set [3] = '{0, 3, 25};
        int y;
        for (int pi = 0; pi < 4; pi++) begin
            for (int ri = 0; ri < 3; ri++) begin
                load_pos(pos_set[pi]);
                ring = W'(ring_set[ri]);
                for (int x = 0; x < 26; x++) begin
                    fwd_valid_in = 1'b1; fwd_in = W'(x);
                    tick();
                    fwd_valid_in = 1'b0;
                    y = model_fwd(x, pos_set[pi], ring_set[ri]);
                    checks++;
                    if (int'(fwd_out) !== y) begin
                        errors++; $display("FAIL sweep_fwd p%0d r%0d x%0d got=%0d exp=%0d", pos_set[pi], ring_set[ri], x, fwd_out, y);
                    end
                    rev_valid_in = 1'b1; rev_in = W'(y);
                    tick();
                    rev_valid_in = 1'b0;
                    checks++;
                    if (int'(rev_out) !== x) begin
                        errors++; $display("FAIL sweep_rev p%0d r%0d y%0d got=%0d exp=%0d", pos_set[pi], ring_set[ri], y, rev_out, x);
                    end
                    $display("txn sweep p=%0d r=%0d x=%0d fwd=%0d back=%0d", pos_set[pi], ring_set[ri], x, fwd_out, rev_out);
                end
            end
        end
        ring = 5'd0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; pos_load = '0; ring = '0; step_in = 1'b0;
        fwd_valid_in = 1'b0; fwd_in = '0; rev_valid_in = 1'b0; rev_in = '0;
        test_reset();
        test_basic_pos0();
        test_load_pos1();
        test_ring();
        test_stepping();
        test_load_priority();
        test_invalid();
        test_reset_midstream();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
